// File: rtl/wb_queue_pkg.sv
// Shared widths and entry type for the register-file writeback queue.
// Optional forwarding is selected with the WBQ_FORWARD_EN macro.
`ifndef WB_QUEUE_PKG_SV
`define WB_QUEUE_PKG_SV
package wb_queue_pkg;
    localparam int                REG_AW   = 5;
    localparam int                DATA_W   = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;
endpackage
`endif

// File: rtl/wb_queue_if.sv
// Producer, regfile-write and decode-lookup signals of the writeback queue.
// Forwarding signals exist only when WBQ_FORWARD_EN is defined.
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int AW = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              regwrite;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    logic [REG_AW-1:0] rreg1;
    logic [REG_AW-1:0] rreg2;
    logic              busy1;
    logic              busy2;
    logic [AW:0]       count;
`ifdef WBQ_FORWARD_EN
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;

    modport master (
        output in_valid, in_reg, in_data, rreg1, rreg2,
        input  in_ready, regwrite, wreg, wdata, busy1, busy2, count,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
    modport slave (
        input  in_valid, in_reg, in_data, rreg1, rreg2,
        output in_ready, regwrite, wreg, wdata, busy1, busy2, count,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
`else
    modport master (
        output in_valid, in_reg, in_data, rreg1, rreg2,
        input  in_ready, regwrite, wreg, wdata, busy1, busy2, count
    );
    modport slave (
        input  in_valid, in_reg, in_data, rreg1, rreg2,
        output in_ready, regwrite, wreg, wdata, busy1, busy2, count
    );
`endif
endinterface

// File: rtl/wb_queue_lookup.sv
// Pending-write lookup for one decode read port: hit plus youngest matching data.
// The data path is present only when WBQ_FORWARD_EN is defined.
module wbq_lookup
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic [REG_AW-1:0]             rreg,
    input  logic [DEPTH-1:0]              vld,
    input  logic [DEPTH-1:0][REG_AW-1:0]  regs,
`ifdef WBQ_FORWARD_EN
    input  logic [DEPTH-1:0][DATA_W-1:0]  datas,
    input  logic [AW-1:0]                 rd_ptr,
    output logic [DATA_W-1:0]             data,
`endif
    output logic                          hit
);
    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = vld[i] && (regs[i] == rreg) && (rreg != REG_ZERO);
    end

    assign hit = |match;

`ifdef WBQ_FORWARD_EN
    logic [AW-1:0] idx;

    // Walk oldest to youngest from the head so the last match wins.
    always_comb begin
        data = '0;
        idx  = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + AW'(k);
            if (match[idx])
                data = datas[idx];
        end
    end
`endif
endmodule

// File: rtl/wb_queue.sv
// Writeback FIFO in front of the regfile write port; retires one entry per cycle
// and flags pending writes to decode. WBQ_FORWARD_EN adds data forwarding.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    wb_queue_if.slave  bus
);
    wbq_entry_t [DEPTH-1:0]             mem;
    logic [DEPTH-1:0]                   vld;
    logic [DEPTH-1:0][REG_AW-1:0]       regs;
    logic [AW-1:0]                      rd_ptr, wr_ptr;
    logic [AW:0]                        cnt;
    logic                               push, pop;

    assign bus.in_ready = (cnt != (AW+1)'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready && (bus.in_reg != REG_ZERO);
    assign pop          = (cnt != '0);

    assign bus.count    = cnt;
    assign bus.regwrite = pop;
    assign bus.wreg     = pop ? mem[rd_ptr].rd   : REG_ZERO;
    assign bus.wdata    = pop ? mem[rd_ptr].data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{rd: bus.in_reg, data: bus.in_data};
    end

`ifdef WBQ_FORWARD_EN
    logic [DEPTH-1:0][DATA_W-1:0] datas;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_split
        assign regs[g] = mem[g].rd;
`ifdef WBQ_FORWARD_EN
        assign datas[g] = mem[g].data;
`endif
    end

`ifdef WBQ_FORWARD_EN
    assign bus.fwd1_hit = bus.busy1;
    assign bus.fwd2_hit = bus.busy2;

    wbq_lookup #(.DEPTH(DEPTH), .AW(AW)) u_look1 (
        .rreg(bus.rreg1), .vld(vld), .regs(regs), .datas(datas),
        .rd_ptr(rd_ptr), .data(bus.fwd1_data), .hit(bus.busy1)
    );
    wbq_lookup #(.DEPTH(DEPTH), .AW(AW)) u_look2 (
        .rreg(bus.rreg2), .vld(vld), .regs(regs), .datas(datas),
        .rd_ptr(rd_ptr), .data(bus.fwd2_data), .hit(bus.busy2)
    );
`else
    wbq_lookup #(.DEPTH(DEPTH), .AW(AW)) u_look1 (
        .rreg(bus.rreg1), .vld(vld), .regs(regs), .hit(bus.busy1)
    );
    wbq_lookup #(.DEPTH(DEPTH), .AW(AW)) u_look2 (
        .rreg(bus.rreg2), .vld(vld), .regs(regs), .hit(bus.busy2)
    );
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: vector table, corner sequences, and a
// reference-queue scoreboard checked every cycle.
module tb_wb_queue;
    import wb_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_queue_if #(.AW(2)) bif();
    wb_queue #(.DEPTH(4), .AW(2)) dut (.clk(clk), .reset(reset), .bus(bif));

    typedef struct packed {
        logic [4:0]  rg;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        v;
        logic [4:0]  rg;
        logic [31:0] d;
        logic [4:0]  r1;
        logic [2:0]  e_cnt;
        logic        e_rw;
        logic        e_rdy;
        logic        e_b1;
        logic [4:0]  e_wreg;
        logic [31:0] e_wd;
    } vec_t;

    ent_t q[$];
    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [4:0] r);
        m_hit = 1'b0;
        foreach (q[i]) if (r != 5'd0 && q[i].rg == r) m_hit = 1'b1;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] r);
        m_fwd = 32'd0;
        foreach (q[i]) if (r != 5'd0 && q[i].rg == r) m_fwd = q[i].d;
    endfunction

    task automatic check_model(input logic [4:0] r1, input logic [4:0] r2);
        chk("in_ready", bif.in_ready, q.size() != 4);
        chk("count",    bif.count,    q.size());
        chk("regwrite", bif.regwrite, q.size() != 0);
        chk("wreg",     bif.wreg,     (q.size() != 0) ? q[0].rg : 5'd0);
        chk("wdata",    bif.wdata,    (q.size() != 0) ? q[0].d : 32'd0);
        chk("busy1",    bif.busy1,    m_hit(r1));
        chk("busy2",    bif.busy2,    m_hit(r2));
`ifdef WBQ_FORWARD_EN
        chk("fwd1_hit",  bif.fwd1_hit,  m_hit(r1));
        chk("fwd2_hit",  bif.fwd2_hit,  m_hit(r2));
        chk("fwd1_data", bif.fwd1_data, m_fwd(r1));
        chk("fwd2_data", bif.fwd2_data, m_fwd(r2));
`endif
    endtask

    task automatic drive(input logic v, input logic [4:0] rg, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input logic rst);
        bif.in_valid = v;
        bif.in_reg   = rg;
        bif.in_data  = d;
        bif.rreg1    = r1;
        bif.rreg2    = r2;
        reset        = rst;
    endtask

    // Scoreboard update at the edge: head retires, accepted nonzero writes enqueue.
    task automatic advance(input logic v, input logic [4:0] rg, input logic [31:0] d,
                           input logic rst);
        logic acc;
        @(posedge clk);
        acc = v && (q.size() != 4) && (rg != 5'd0);
        if (rst) q.delete();
        else begin
            if (q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back('{rg: rg, d: d});
        end
        #1;
    endtask

    task automatic cycle(input logic v, input logic [4:0] rg, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input logic rst);
        drive(v, rg, d, r1, r2, rst);
        @(negedge clk);
        check_model(r1, r2);
        advance(v, rg, d, rst);
    endtask

    initial begin
        // v rg data r1 | cnt rw rdy busy1 wreg wdata
        tbl[0] = '{1'b0, 5'd0, 32'h0,        5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[1] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        5'd5, 3'd1, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd5, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[4] = '{1'b1, 5'd0, 32'h1234,     5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[6] = '{1'b1, 5'd7, 32'h1,        5'd7, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[7] = '{1'b1, 5'd7, 32'h2,        5'd7, 3'd1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        5'd7, 3'd1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h2};
        tbl[9] = '{1'b0, 5'd0, 32'h0,        5'd7, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};

        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].rg, tbl[i].d, tbl[i].r1, 5'd5, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl%0d_count", i),    bif.count,    tbl[i].e_cnt);
            chk($sformatf("tbl%0d_regwrite", i), bif.regwrite, tbl[i].e_rw);
            chk($sformatf("tbl%0d_in_ready", i), bif.in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busy1", i),    bif.busy1,    tbl[i].e_b1);
            chk($sformatf("tbl%0d_wreg", i),     bif.wreg,     tbl[i].e_wreg);
            chk($sformatf("tbl%0d_wdata", i),    bif.wdata,    tbl[i].e_wd);
`ifdef WBQ_FORWARD_EN
            chk($sformatf("tbl%0d_fwd1", i),     bif.fwd1_data, tbl[i].e_b1 ? tbl[i].e_wd : 32'd0);
`endif
            check_model(tbl[i].r1, 5'd5);
            advance(tbl[i].v, tbl[i].rg, tbl[i].d, 1'b0);
        end

        // Back-to-back burst; retire order and ready tracked by the scoreboard.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 5'(11 + i), 32'h111 * (i + 1), 5'd13, 5'd15, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 5'd0, 32'd0, 5'd13, 5'd15, 1'b0);

        // Reset while writes are pending and another is arriving.
        cycle(1'b1, 5'd9,  32'hAAAA, 5'd9, 5'd10, 1'b0);
        cycle(1'b1, 5'd10, 32'hBBBB, 5'd9, 5'd10, 1'b0);
        cycle(1'b1, 5'd12, 32'hCCCC, 5'd9, 5'd12, 1'b1);
        drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd12, 1'b0);
        @(negedge clk);
        chk("rst_count",    bif.count,    32'd0);
        chk("rst_regwrite", bif.regwrite, 32'd0);
        chk("rst_busy2",    bif.busy2,    32'd0);
        advance(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++)
            cycle(1'b0, 5'd0, 32'd0, 5'd10, 5'd12, 1'b0);

        for (int i = 0; i < 80; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
